// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host port: FSM states, key event record, prefix codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_REQ,
    TX_BITS,
    TX_PARITY,
    TX_STOP,
    TX_ACK
  } tx_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ps2_event_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  // Parity bit that makes the 9-bit group {b, p} odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO, power-of-2 DEPTH; a push while full succeeds only if a pop happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  ps2_event_t wdata_i,
  input  logic       pop_i,
  output ps2_event_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  ps2_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_host.sv
// PS/2 host port: deglitched receive, E0/F0 key-event decode into a FIFO, optional host-to-device
// transmit built when PS2_HOST_TX_EN is defined.
module ps2_host
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 16,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned INHIBIT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic       rx_en,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic       overflow,
  output logic       frame_err,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack
);

  localparam logic [FILTER_LEN-1:0] FEDGE_PAT =
    {{(FILTER_LEN/4){1'b1}}, {(3*FILTER_LEN/4){1'b0}}};

  logic [1:0]            clk_sync_q, data_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic [TIMEOUT_W-1:0]  to_cnt_q;
  rx_state_e             rx_state_q, rx_state_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic                  ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d, ovf_q;

  logic       data_s, fedge, timeout, tx_idle, tx_accept;
  logic       rx_adv, rx_step, par_ok, push;
  logic       fifo_full, fifo_empty;
  ps2_event_t ev_in, ev_head;

  assign data_s  = data_sync_q[1];
  assign fedge   = (hist_q == FEDGE_PAT);
  assign timeout = &to_cnt_q;
  assign rx_adv  = fedge & rx_en & tx_idle;
  assign rx_step = rx_adv & ~timeout;
  assign par_ok  = ^{rx_shift_q, data_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      hist_q      <= '1;
      to_cnt_q    <= '0;
      rx_state_q  <= RX_IDLE;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2clk_ext};
      data_sync_q <= {data_sync_q[0], ps2data_ext};
      hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      // Clearing on tx acceptance too keeps a free-running count from aborting a fresh transmit.
      if ((fedge & (rx_en | ~tx_idle)) | tx_accept) to_cnt_q <= '0;
      else                                          to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      if (push & fifo_full & ~ev_ready) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    if (timeout) begin
      rx_state_d = RX_IDLE;
    end else if (rx_adv) begin
      unique case (rx_state_q)
        RX_IDLE: if (!data_s) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = '0;
        end
        RX_DATA: begin
          rx_shift_d = {data_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: rx_state_d = par_ok ? RX_STOP : RX_IDLE;
        RX_STOP:   rx_state_d = RX_IDLE;
        default:   rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_err  = rx_step & (((rx_state_q == RX_PARITY) & ~par_ok) |
                            ((rx_state_q == RX_STOP) & ~data_s));
    push       = 1'b0;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    if (rx_step && rx_state_q == RX_STOP && data_s) begin
      if (rx_shift_q == PS2_PREFIX_EXT)      ext_pend_d = 1'b1;
      else if (rx_shift_q == PS2_PREFIX_REL) rel_pend_d = 1'b1;
      else begin
        push       = 1'b1;
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end
    end
  end

  assign ev_in.code = rx_shift_q;
  assign ev_in.ext  = ext_pend_q;
  assign ev_in.rel  = rel_pend_q;

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (ev_in),
    .pop_i   (ev_ready),
    .rdata_o (ev_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_code  = ev_head.code;
  assign ev_ext   = ev_head.ext;
  assign ev_rel   = ev_head.rel;
  assign overflow = ovf_q;

`ifdef PS2_HOST_TX_EN
  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic             rx_start, clk_oe_c, data_oe_c, ready_c;

  assign rx_start  = rx_step & (rx_state_q == RX_IDLE) & ~data_s;
  assign tx_idle   = (tx_state_q == TX_IDLE);
  assign ready_c   = tx_idle & (rx_state_q == RX_IDLE) & ~rx_start;
  assign tx_accept = tx_valid & ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_byte_q  <= '0;
      tx_bit_q   <= '0;
      inh_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_byte_q  <= tx_byte_d;
      tx_bit_q   <= tx_bit_d;
      inh_q      <= inh_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    tx_bit_d   = tx_bit_q;
    inh_d      = inh_q;
    if (!tx_idle && timeout) begin
      tx_state_d = TX_IDLE;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: if (tx_accept) begin
          tx_state_d = TX_INHIBIT;
          tx_byte_d  = tx_data;
          inh_d      = '0;
        end
        TX_INHIBIT: begin
          inh_d = inh_q + INH_W'(1);
          if (inh_q == INH_LAST) tx_state_d = TX_REQ;
        end
        TX_REQ: if (fedge) begin
          tx_state_d = TX_BITS;
          tx_bit_d   = '0;
        end
        TX_BITS: if (fedge) begin
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_PARITY;
        end
        TX_PARITY: if (fedge) tx_state_d = TX_STOP;
        TX_STOP:   if (fedge) tx_state_d = TX_ACK;
        TX_ACK:    if (fedge) tx_state_d = TX_IDLE;
        default:   tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    clk_oe_c  = (tx_state_q == TX_INHIBIT);
    data_oe_c = 1'b0;
    unique case (tx_state_q)
      TX_REQ:    data_oe_c = 1'b1;
      TX_BITS:   data_oe_c = ~tx_byte_q[tx_bit_q];
      TX_PARITY: data_oe_c = ~odd_parity(tx_byte_q);
      default:   data_oe_c = 1'b0;
    endcase
    tx_done = (~tx_idle & timeout) | ((tx_state_q == TX_ACK) & fedge & ~timeout);
    tx_ack  = (tx_state_q == TX_ACK) & fedge & ~timeout & ~data_s;
  end

  // Reset releases the lines combinationally so a mid-frame reset frees the bus at once.
  assign ps2clk_oe  = clk_oe_c & ~rst;
  assign ps2data_oe = data_oe_c & ~rst;
  assign tx_ready   = ready_c & ~rst;
`else
  logic unused_tx;
  assign unused_tx  = ^{tx_valid, tx_data};
  assign tx_idle    = 1'b1;
  assign tx_accept  = 1'b0;
  assign ps2clk_oe  = 1'b0;
  assign ps2data_oe = 1'b0;
  assign tx_ready   = 1'b0;
  assign tx_done    = 1'b0;
  assign tx_ack     = 1'b0;
`endif

endmodule
